isa_bus_sequencer: RTL and testbench

- Parametrised ISA I/O bus-cycle sequencer. It drives the address latch, data latch, IOR#/IOW# strobes and control-register clear for one 8-bit I/O read or write per request.
- It sits between the host control register (read/write request bits) and the ISA-side latches and strobes.
- It generalises the fixed 5-cycle strobe engine with configurable setup, strobe and hold lengths, IOCHRDY wait-state extension, a ready timeout with an error flag, and busy/done status.

---
 rtl/isa_bus_sequencer.sv | 132 +++++++++++++
 tb/tb_isa_bus_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/isa_bus_sequencer.sv
// isa_bus_sequencer: one 8-bit ISA I/O read or write per request, with configurable
// setup/strobe/hold lengths, IOCHRDY wait states and a ready timeout.
module isa_bus_sequencer #(
    parameter int ADDR_SETUP_CYCLES = 1,
    parameter int STROBE_CYCLES     = 4,
    parameter int HOLD_CYCLES       = 1,
    parameter int READY_TIMEOUT     = 64,
    parameter int CNT_W             = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic       iochrdy,
    output logic       data_load,
    output logic       data_read,
    output logic       address_load,
    output logic       iow,
    output logic       ior,
    output logic       control_reset,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [3:0] state_debug
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR   = 4'd1,
        S_PREP   = 4'd2,
        S_STROBE = 4'd3,
        S_WAIT   = 4'd4,
        S_LATCH  = 4'd5,
        S_HOLD   = 4'd6,
        S_CRST   = 4'd7
    } state_t;

    localparam int MAX_A = ADDR_SETUP_CYCLES > STROBE_CYCLES ? ADDR_SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_H = HOLD_CYCLES > READY_TIMEOUT ? HOLD_CYCLES : READY_TIMEOUT;
    localparam int MAX_P = MAX_A > MAX_H ? MAX_A : MAX_H;

    if (ADDR_SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1 || READY_TIMEOUT < 1 ||
        CNT_W < 1 || CNT_W > 30 || MAX_P > (1 << CNT_W) - 1) begin : g_bad_cfg
        $error("isa_bus_sequencer: cycle parameters must be >= 1 and fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(READY_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rd_q, rd_d;
    logic             timeout_q, timeout_d;
    logic             sync1_q, sync_q;
    logic             data_load_q, data_read_q, address_load_q, iow_q, ior_q, control_reset_q;
    logic             busy_q, done_q;
    logic             strobe_d;

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: if (rd_req || wr_req) begin
                state_d   = S_ADDR;
                rd_d      = rd_req;
                timeout_d = 1'b0;
            end
            S_ADDR:   state_d = cnt_q == ADDR_LAST ? S_PREP : S_ADDR;
            S_PREP:   state_d = S_STROBE;
            S_STROBE: state_d = cnt_q != STB_LAST ? S_STROBE : sync_q ? S_LATCH : S_WAIT;
            S_WAIT: if (sync_q) state_d = S_LATCH;
                else if (cnt_q == TO_LAST) begin
                    state_d   = S_HOLD;
                    timeout_d = 1'b1;
                end
            S_LATCH:  state_d = S_HOLD;
            S_HOLD:   state_d = cnt_q == HOLD_LAST ? S_CRST : S_HOLD;
            S_CRST:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign strobe_d = state_d == S_STROBE || state_d == S_WAIT || state_d == S_LATCH;

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            rd_q            <= 1'b0;
            timeout_q       <= 1'b0;
            sync1_q         <= 1'b1;
            sync_q          <= 1'b1;
            data_load_q     <= 1'b1;
            data_read_q     <= 1'b1;
            address_load_q  <= 1'b1;
            iow_q           <= 1'b1;
            ior_q           <= 1'b1;
            control_reset_q <= 1'b1;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
            rd_q            <= rd_d;
            timeout_q       <= timeout_d;
            sync1_q         <= iochrdy;
            sync_q          <= sync1_q;
            data_load_q     <= !(state_d == S_PREP && !rd_d);
            data_read_q     <= !(state_d == S_LATCH && rd_d);
            address_load_q  <= state_d != S_ADDR;
            iow_q           <= !(strobe_d && !rd_d);
            ior_q           <= !(strobe_d && rd_d);
            control_reset_q <= state_d != S_CRST;
            busy_q          <= state_d != S_IDLE;
            done_q          <= state_d == S_CRST;
        end
    end

    assign data_load     = data_load_q;
    assign data_read     = data_read_q;
    assign address_load  = address_load_q;
    assign iow           = iow_q;
    assign ior           = ior_q;
    assign control_reset = control_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign state_debug   = state_q;
endmodule

// File: tb/tb_isa_bus_sequencer.sv
// tb_isa_bus_sequencer: directed bus cycles on three parameterisations, checked
// cycle by cycle against an expected-output queue built from the timing model.
module tb_isa_bus_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       rd[3], wr[3], rdy[3];
    logic       dl[3], dr[3], al[3], iw[3], ir[3], cr[3], bz[3], dn[3], tm[3];
    logic [3:0] sd[3];

    isa_bus_sequencer u0 (
        .clk(clk), .reset(reset), .rd_req(rd[0]), .wr_req(wr[0]), .iochrdy(rdy[0]),
        .data_load(dl[0]), .data_read(dr[0]), .address_load(al[0]), .iow(iw[0]), .ior(ir[0]),
        .control_reset(cr[0]), .busy(bz[0]), .done(dn[0]), .timeout(tm[0]), .state_debug(sd[0])
    );
    isa_bus_sequencer #(.READY_TIMEOUT(8)) u1 (
        .clk(clk), .reset(reset), .rd_req(rd[1]), .wr_req(wr[1]), .iochrdy(rdy[1]),
        .data_load(dl[1]), .data_read(dr[1]), .address_load(al[1]), .iow(iw[1]), .ior(ir[1]),
        .control_reset(cr[1]), .busy(bz[1]), .done(dn[1]), .timeout(tm[1]), .state_debug(sd[1])
    );
    isa_bus_sequencer #(.ADDR_SETUP_CYCLES(3), .STROBE_CYCLES(2), .HOLD_CYCLES(2)) u2 (
        .clk(clk), .reset(reset), .rd_req(rd[2]), .wr_req(wr[2]), .iochrdy(rdy[2]),
        .data_load(dl[2]), .data_read(dr[2]), .address_load(al[2]), .iow(iw[2]), .ior(ir[2]),
        .control_reset(cr[2]), .busy(bz[2]), .done(dn[2]), .timeout(tm[2]), .state_debug(sd[2])
    );

    int tests = 0;
    int fails = 0;
    logic [12:0] q[$];

    function automatic logic [12:0] obs(int i);
        return {dl[i], dr[i], al[i], iw[i], ir[i], cr[i], bz[i], dn[i], tm[i], sd[i]};
    endfunction

    // Expected outputs in cycle k after a request seen at cycle 0 (w = WAIT cycles).
    function automatic logic [12:0] expv(int k, bit r, int a, int s, int h, int w, bit to);
        int st, b, hb;
        logic stb;
        b  = a + 2 + s + w;
        hb = to ? b : b + 1;
        if (k <= 0) st = 0;
        else if (k <= a) st = 1;
        else if (k == a + 1) st = 2;
        else if (k <= a + 1 + s) st = 3;
        else if (k <= a + 1 + s + w) st = 4;
        else if (!to && k == b) st = 5;
        else if (k < hb + h) st = 6;
        else if (k == hb + h) st = 7;
        else st = 0;
        stb = st == 3 || st == 4 || st == 5;
        return {!(st == 2 && !r), !(st == 5 && r), st != 1, !(stb && !r), !(stb && r),
                st != 7, st != 0, st == 7, to && k >= b, 4'(st)};
    endfunction

    task automatic check(string tag, int k, logic [12:0] got, logic [12:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: got %b expected %b", tag, k, got, exp);
        end
    endtask

    task automatic run(string tag, int i, bit r, bit w, int a, int s, int h, int wt, bit to,
                       int n, int rise);
        for (int k = 1; k <= n; k++) q.push_back(expv(k, r, a, s, h, wt, to));
        @(negedge clk);
        rd[i] = r;
        wr[i] = w;
        if (rise >= 0) rdy[i] = 1'b0;
        @(posedge clk);
        #1;
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check(tag, k, obs(i), q.pop_front());
            if (k == rise) rdy[i] = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rd[i]  = 1'b0;
            wr[i]  = 1'b0;
            rdy[i] = 1'b1;
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check("reset", 0, obs(i), expv(0, 1, 1, 4, 1, 0, 0));
        reset = 1'b1;
        run("read", 0, 1, 0, 1, 4, 1, 0, 0, 11, -1);
        run("write", 0, 0, 1, 1, 4, 1, 0, 0, 11, -1);
        run("wait_read", 0, 1, 0, 1, 4, 1, 6, 0, 16, 10);
        run("timeout", 1, 1, 0, 1, 4, 1, 8, 1, 18, 1000);
        @(negedge clk);
        check("timeout_sticky", 19, obs(1), expv(19, 1, 1, 4, 1, 8, 1));
        rdy[1] = 1'b1;
        repeat (3) @(negedge clk);
        run("timeout_clear", 1, 1, 0, 1, 4, 1, 0, 0, 11, -1);
        run("cfg_write", 2, 0, 1, 3, 2, 2, 0, 0, 12, -1);
        run("both_req", 0, 1, 1, 1, 4, 1, 0, 0, 5, -1);
        reset = 1'b0;
        #1;
        check("abort", 5, obs(0), expv(0, 1, 1, 4, 1, 0, 0));
        for (int k = 6; k < 9; k++) begin
            @(negedge clk);
            check("abort_hold", k, obs(0), expv(0, 1, 1, 4, 1, 0, 0));
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("after_abort", 0, obs(0), expv(0, 1, 1, 4, 1, 0, 0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
